pio_reg_arbiter: RTL and testbench

Round-robin arbiter and access sequencer sharing the single-port PIO register block between `NREQ` bus requesters, e.g. core 0, core 1 and DMA. Each requester issues one read or write at a time through a req/ack handshake. The arbiter serialises the accesses onto the register block's `sel`/`RW`/`addr`/`wdata` port and returns read data, which arrives one cycle after `sel`. It also honours the block's `busy` input and aborts with an error after a bounded number of stalled cycles.

---
 rtl/pio_reg_arbiter.sv | 135 +++++++++++++
 tb/tb_pio_reg_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pio_reg_arbiter.sv
// Round-robin arbiter that serialises NREQ requesters onto the single-port PIO register block,
// with read-data return and a bounded busy-stall timeout.
module pio_reg_arbiter #(
   parameter int NREQ    = 2,
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          req_rw,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_wdata,
   output logic [NREQ-1:0]          ack,
   output logic                     err,
   output logic [DATA_W-1:0]        resp_rdata,
   output logic                     pio_sel,
   output logic                     pio_rw,
   output logic [ADDR_W-1:0]        pio_addr,
   output logic [DATA_W-1:0]        pio_wdata,
   input  logic [DATA_W-1:0]        pio_rdata,
   input  logic                     pio_busy
);

   localparam int IDX_W = (NREQ > 2) ? 2 : 1;
   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   ptr, grant, winner, cand;
   logic               found;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               lat_rw;
   logic [ADDR_W-1:0]  lat_addr;
   logic [DATA_W-1:0]  lat_wdata;

   // Cyclic search starting at the pointer; the first set request wins.
   always_comb begin
      // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
      winner = '0;
      found  = 1'b0;
      cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         // NOTE: blocking '=' in combinational logic so later iterations see the updated flags.
         cand = IDX_W'((int'(ptr) + i) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      ack        = '0;
      err        = 1'b0;
      resp_rdata = '0;
      pio_sel    = 1'b0;
      pio_rw     = 1'b0;
      pio_addr   = '0;
      pio_wdata  = '0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = ISSUE;
               cnt_nxt   = '0;
            end
         end
         ISSUE: begin
            if (!pio_busy) begin
               pio_sel   = 1'b1;
               pio_rw    = lat_rw;
               pio_addr  = lat_addr;
               pio_wdata = lat_wdata;
               if (lat_rw) begin
                  ack[grant] = 1'b1;
                  state_nxt  = IDLE;
               end else begin
                  state_nxt = RESP;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
               // Give up without ever issuing the access.
               if (cnt == CNT_W'(TIMEOUT - 1)) begin
                  ack[grant] = 1'b1;
                  err        = 1'b1;
                  state_nxt  = IDLE;
               end
            end
         end
         RESP: begin
            ack[grant] = 1'b1;
            resp_rdata = pio_rdata;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // A reset coinciding with a completion suppresses it; the transaction is abandoned.
      if (reset) begin
         ack        = '0;
         err        = 1'b0;
         resp_rdata = '0;
         pio_sel    = 1'b0;
         pio_rw     = 1'b0;
         pio_addr   = '0;
         pio_wdata  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ptr       <= '0;
         grant     <= '0;
         cnt       <= '0;
         lat_rw    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == IDLE && found) begin
            grant     <= winner;
            ptr       <= IDX_W'((int'(winner) + 1) % NREQ);
            lat_rw    <= req_rw[winner];
            lat_addr  <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[int'(winner)*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: tb/tb_pio_reg_arbiter.sv
// Directed bench for pio_reg_arbiter (NREQ=2, TIMEOUT=16): scoreboard of expected completions
// checked by a negedge monitor, plus cycle-exact checks in the stimulus sequence.
module tb_pio_reg_arbiter;

   localparam int NREQ = 2, ADDR_W = 12, DATA_W = 32, TIMEOUT = 16;

   logic                   clk = 1'b0;
   logic                   reset;
   logic [NREQ-1:0]        req, req_rw, ack;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ*DATA_W-1:0] req_wdata;
   logic                   err, pio_sel, pio_rw, pio_busy;
   logic [DATA_W-1:0]      resp_rdata, pio_wdata, pio_rdata;
   logic [ADDR_W-1:0]      pio_addr;

   typedef struct {
      int          idx;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic [NREQ-1:0] mon_onehot;
   int n_chk  = 0;
   int n_pass = 0;

   pio_reg_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
      .req_wdata(req_wdata), .ack(ack), .err(err), .resp_rdata(resp_rdata),
      .pio_sel(pio_sel), .pio_rw(pio_rw), .pio_addr(pio_addr), .pio_wdata(pio_wdata),
      .pio_rdata(pio_rdata), .pio_busy(pio_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input int idx, input logic e, input logic [31:0] rd);
      exp_t x;
      x.idx = idx; x.err = e; x.rdata = rd;
      sb.push_back(x);
   endtask

   // Completion monitor: every ack must match the oldest expected completion.
   always @(negedge clk) begin
      if (ack !== '0) begin
         check("ack_onehot", 64'($countones(ack)), 64'd1);
         if (sb.size() == 0) begin
            check("ack_unexpected", 64'(ack), 64'd0);
         end else begin
            mon_e      = sb.pop_front();
            mon_onehot = NREQ'(1) << mon_e.idx;
            check("sb_ack", 64'(ack), 64'(mon_onehot));
            check("sb_err", 64'(err), 64'(mon_e.err));
            check("sb_rdata", 64'(resp_rdata), 64'(mon_e.rdata));
         end
      end
      if (!pio_sel) check("sel_low_zero", 64'({pio_rw, pio_addr, pio_wdata}), 64'd0);
   end

   initial begin
      reset = 1'b1; req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
      pio_rdata = '0; pio_busy = 1'b0;
      tick(); tick(); mid();
      check("rst_outputs", 64'({ack, err, pio_sel, resp_rdata}), 64'd0);

      // Single write from requester 0
      tick(); reset = 1'b0;
      req[0] = 1'b1; req_rw[0] = 1'b1; req_addr[0 +: ADDR_W] = 12'h000;
      req_wdata[0 +: DATA_W] = 32'h0000_0F0F; push(0, 1'b0, 32'h0);
      mid(); check("wr_c0_sel", 64'(pio_sel), 64'd0);
      tick(); mid();
      check("wr_c1_pio", 64'({pio_sel, pio_rw, pio_addr, pio_wdata}), {19'd0, 1'b1, 1'b1, 12'h000, 32'h0000_0F0F});
      check("wr_c1_ack", 64'({ack, err}), 64'({2'b01, 1'b0}));
      tick(); req = '0; mid(); check("wr_c2_ack", 64'(ack), 64'd0);

      // Single read from requester 1
      tick(); req[1] = 1'b1; req_rw[1] = 1'b0; req_addr[ADDR_W +: ADDR_W] = 12'h0C8;
      pio_rdata = 32'h0001_0000; push(1, 1'b0, 32'h0001_0000);
      mid();
      tick(); mid();
      check("rd_c1_pio", 64'({pio_sel, pio_rw, pio_addr}), 64'({1'b1, 1'b0, 12'h0C8}));
      check("rd_c1_ack", 64'(ack), 64'd0);
      tick(); mid();
      check("rd_c2_ack", 64'(ack), 64'(2'b10));
      check("rd_c2_rdata", 64'(resp_rdata), 64'h0001_0000);
      tick(); req = '0; mid();

      // Contention from reset: writes alternate 0,1,0,1
      tick(); reset = 1'b1; req = 2'b11; req_rw = 2'b11;
      req_addr = {12'h020, 12'h010}; req_wdata = {32'h2222_2222, 32'h1111_1111};
      push(0, 1'b0, 32'h0); push(1, 1'b0, 32'h0); push(0, 1'b0, 32'h0); push(1, 1'b0, 32'h0);
      tick(); reset = 1'b0; mid();
      check("rot_c0_ack", 64'(ack), 64'd0);
      for (int c = 1; c <= 8; c++) begin
         logic [1:0] exp_ack;
         tick();
         if (c == 8) req = '0;
         mid();
         exp_ack = (c % 2 == 0) ? 2'b00 : (((c / 2) % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("rot_c%0d_ack", c), 64'(ack), 64'(exp_ack));
         if (c % 2 == 1)
            check($sformatf("rot_c%0d_addr", c), 64'(pio_addr), (exp_ack == 2'b01) ? 64'h010 : 64'h020);
      end

      // Busy for three cycles after grant delays a write to cycle 4
      tick(); req[0] = 1'b1; req_rw[0] = 1'b1; req_addr[0 +: ADDR_W] = 12'h100;
      req_wdata[0 +: DATA_W] = 32'h0000_ABCD; push(0, 1'b0, 32'h0);
      mid();
      for (int c = 1; c <= 3; c++) begin
         tick(); pio_busy = 1'b1; mid();
         check($sformatf("stall_c%0d", c), 64'({pio_sel, ack}), 64'd0);
      end
      tick(); pio_busy = 1'b0; mid();
      check("stall_c4_pio", 64'({pio_sel, pio_addr, pio_wdata}), 64'({1'b1, 12'h100, 32'h0000_ABCD}));
      check("stall_c4_ack", 64'(ack), 64'(2'b01));
      tick(); req = '0; mid();

      // Permanent busy: read aborts with err in cycle TIMEOUT
      tick(); req[1] = 1'b1; req_rw[1] = 1'b0; req_addr[ADDR_W +: ADDR_W] = 12'h0FF;
      push(1, 1'b1, 32'h0); mid();
      for (int c = 1; c <= TIMEOUT; c++) begin
         tick(); pio_busy = 1'b1; mid();
         check($sformatf("to_c%0d_sel", c), 64'(pio_sel), 64'd0);
         if (c < TIMEOUT) check($sformatf("to_c%0d_ack", c), 64'(ack), 64'd0);
      end
      check("to_ack_err", 64'({ack, err}), 64'({2'b10, 1'b1}));
      check("to_rdata", 64'(resp_rdata), 64'd0);
      tick(); req = '0; pio_busy = 1'b0; mid();
      check("to_after_ack", 64'(ack), 64'd0);

      // Reset during the ISSUE cycle of a read abandons it
      tick(); req[0] = 1'b1; req_rw[0] = 1'b0; req_addr[0 +: ADDR_W] = 12'h044; mid();
      tick(); reset = 1'b1; req = '0; mid();
      tick(); reset = 1'b0; mid();
      check("rstmid_c2", 64'({ack, err, pio_sel, resp_rdata}), 64'd0);
      tick(); mid();
      check("rstmid_c3", 64'({ack, err, pio_sel, resp_rdata}), 64'd0);
      tick(); req = 2'b11; req_rw = 2'b11; req_addr = {12'h0B0, 12'h0A0}; push(0, 1'b0, 32'h0); mid();
      tick(); mid();
      check("rstmid_win0", 64'({ack, pio_addr}), 64'({2'b01, 12'h0A0}));
      tick(); req = '0; mid();

      // Requester inputs changing after the grant do not reach the block
      tick(); req[1] = 1'b1; req_rw[1] = 1'b1; req_addr[ADDR_W +: ADDR_W] = 12'h123;
      req_wdata[DATA_W +: DATA_W] = 32'h0000_5555; push(1, 1'b0, 32'h0); mid();
      tick(); req_addr[ADDR_W +: ADDR_W] = 12'h3FF; req_wdata[DATA_W +: DATA_W] = 32'h0000_AAAA;
      pio_busy = 1'b1; mid();
      check("chg_c1_sel", 64'(pio_sel), 64'd0);
      tick(); pio_busy = 1'b0; mid();
      check("chg_c2_pio", 64'({pio_sel, pio_addr, pio_wdata}), 64'({1'b1, 12'h123, 32'h0000_5555}));
      check("chg_c2_ack", 64'(ack), 64'(2'b10));
      tick(); req = '0; mid();

      tick(); tick(); mid();
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
